// File: rtl/sky130_fd_io__hvclamp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__hvclamp_pkg
// Description : Shared state codes and output-decode constants for the HV
//               ESD clamp sequencer (drn_hvc / ogc_hvc / src_bdy_hvc domain).
// Revision    : 1.0 - initial release
// ============================================================================
package sky130_fd_io__hvclamp_pkg;

    localparam int c_state_w = 3;

    // State encoding; codes 6 and 7 are unused and recover to OFF.
    localparam logic [c_state_w-1:0] c_st_off      = 3'd0;
    localparam logic [c_state_w-1:0] c_st_debounce = 3'd1;
    localparam logic [c_state_w-1:0] c_st_settle   = 3'd2;
    localparam logic [c_state_w-1:0] c_st_active   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_test     = 3'd4;
    localparam logic [c_state_w-1:0] c_st_fault    = 3'd5;

    // Output bundle driven by the sequencer.
    typedef struct packed {
        logic clamp_force;
        logic trig_en;
        logic ready;
        logic test_ack;
        logic fault;
    } hvc_out_t;

    // Per-state output values. In TEST the clamp_force bit is replaced by
    // the live test_force input, so the constant carries 0 there.
    localparam hvc_out_t c_out_off = '{
        clamp_force: 1'b1, trig_en: 1'b0, ready: 1'b0, test_ack: 1'b0, fault: 1'b0};
    localparam hvc_out_t c_out_debounce = '{
        clamp_force: 1'b1, trig_en: 1'b0, ready: 1'b0, test_ack: 1'b0, fault: 1'b0};
    localparam hvc_out_t c_out_settle = '{
        clamp_force: 1'b1, trig_en: 1'b1, ready: 1'b0, test_ack: 1'b0, fault: 1'b0};
    localparam hvc_out_t c_out_active = '{
        clamp_force: 1'b0, trig_en: 1'b1, ready: 1'b1, test_ack: 1'b0, fault: 1'b0};
    localparam hvc_out_t c_out_test = '{
        clamp_force: 1'b0, trig_en: 1'b0, ready: 1'b0, test_ack: 1'b1, fault: 1'b0};
    localparam hvc_out_t c_out_fault = '{
        clamp_force: 1'b1, trig_en: 1'b0, ready: 1'b0, test_ack: 1'b0, fault: 1'b1};

    // Output values for a given state; test_force only matters in TEST.
    function automatic hvc_out_t f_decode(input logic [c_state_w-1:0] st,
                                          input logic                 test_force);
        hvc_out_t v;
        case (st)
            c_st_off:      v = c_out_off;
            c_st_debounce: v = c_out_debounce;
            c_st_settle:   v = c_out_settle;
            c_st_active:   v = c_out_active;
            c_st_test: begin
                v             = c_out_test;
                v.clamp_force = test_force;
            end
            c_st_fault:    v = c_out_fault;
            default:       v = c_out_off;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sky130_fd_io__hvclamp_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__hvclamp_cnt
// Description : Loadable down-counter that saturates at zero, used to time
//               the supply debounce and clamp settle windows.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_fd_io__hvclamp_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero (no wrap).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sky130_fd_io__hvclamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__hvclamp_ctrl
// Description : Power-up sequencer for the standalone HV ESD clamp. Holds the
//               clamp fully on while supplies ramp, hands over to the RC
//               trigger once supplies have settled, and offers a req/ack
//               override for ATE leakage and trigger checks.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_fd_io__hvclamp_ctrl
    import sky130_fd_io__hvclamp_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int SETTLE_CYC   = 64,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vdd_good,
    input  logic       vddio_good,
    input  logic       test_req,
    input  logic       test_force,
    input  logic       fault_clr,
    output logic       clamp_force,
    output logic       trig_en,
    output logic       ready,
    output logic       test_ack,
    output logic       fault,
    output logic [2:0] state
);

    // Both window lengths must fit the shared counter and be non-zero.
    generate
        if ((DEBOUNCE_CYC < 1) || (DEBOUNCE_CYC > (2 ** CNT_W) - 1)) begin : g_bad_debounce
            $error("sky130_fd_io__hvclamp_ctrl: DEBOUNCE_CYC out of range");
        end
        if ((SETTLE_CYC < 1) || (SETTLE_CYC > (2 ** CNT_W) - 1)) begin : g_bad_settle
            $error("sky130_fd_io__hvclamp_ctrl: SETTLE_CYC out of range");
        end
    endgenerate

    // Counter reload values: the window ends on the edge where the counter
    // reads zero, so loading N-1 gives exactly N cycles in the state.
    localparam logic [CNT_W-1:0] c_deb_load    = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYC - 1);

    logic [c_state_w-1:0] r_state;
    hvc_out_t             r_out;

    logic [c_state_w-1:0] w_state_nxt;
    logic                 w_sup_ok;
    logic                 w_cnt_load;
    logic [CNT_W-1:0]     w_cnt_load_val;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;

    assign w_sup_ok = vdd_good & vddio_good;

    sky130_fd_io__hvclamp_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    // Next-state and counter control; supply loss always wins over test_req.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        w_cnt_dec      = 1'b0;
        case (r_state)
            c_st_off: begin
                if (w_sup_ok) begin
                    w_state_nxt    = c_st_debounce;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_deb_load;
                end
            end
            c_st_debounce: begin
                if (!w_sup_ok) begin
                    w_state_nxt = c_st_off;
                end else if (w_cnt_zero) begin
                    w_state_nxt    = c_st_settle;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = c_settle_load;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            c_st_settle: begin
                if (!w_sup_ok) begin
                    w_state_nxt = c_st_off;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_st_active;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            c_st_active: begin
                if (!w_sup_ok) begin
                    w_state_nxt = c_st_fault;
                end else if (test_req) begin
                    w_state_nxt = c_st_test;
                end
            end
            c_st_test: begin
                if (!w_sup_ok) begin
                    w_state_nxt = c_st_fault;
                end else if (!test_req) begin
                    w_state_nxt = c_st_active;
                end
            end
            c_st_fault: begin
                // FAULT is sticky until software clears it.
                if (fault_clr) begin
                    if (w_sup_ok) begin
                        w_state_nxt    = c_st_debounce;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = c_deb_load;
                    end else begin
                        w_state_nxt = c_st_off;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_off;
            end
        endcase
    end

    // State register with outputs decoded from the next state so every
    // output is a flop and changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_off;
            r_out   <= c_out_off;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= f_decode(w_state_nxt, test_force);
        end
    end

    assign state       = r_state;
    assign clamp_force = r_out.clamp_force;
    assign trig_en     = r_out.trig_en;
    assign ready       = r_out.ready;
    assign test_ack    = r_out.test_ack;
    assign fault       = r_out.fault;

endmodule
`default_nettype wire

// File: tb/tb_sky130_fd_io__hvclamp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky130_fd_io__hvclamp_ctrl
// Description : Self-checking bench for the HV clamp sequencer: directed
//               scenarios plus a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sky130_fd_io__hvclamp_ctrl;

    localparam int DEB = 16;
    localparam int SET = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       vdd_good;
    logic       vddio_good;
    logic       test_req;
    logic       test_force;
    logic       fault_clr;
    logic       clamp_force;
    logic       trig_en;
    logic       ready;
    logic       test_ack;
    logic       fault;
    logic [2:0] state;

    logic [7:0] obs;
    assign obs = {state, clamp_force, trig_en, ready, test_ack, fault};

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: phase number plus cycles spent in the timed phase.
    int   m_st;
    int   m_el;
    logic m_tf;

    sky130_fd_io__hvclamp_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .SETTLE_CYC   (SET),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vdd_good    (vdd_good),
        .vddio_good  (vddio_good),
        .test_req    (test_req),
        .test_force  (test_force),
        .fault_clr   (fault_clr),
        .clamp_force (clamp_force),
        .trig_en     (trig_en),
        .ready       (ready),
        .test_ack    (test_ack),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_vec(input logic [2:0] st, input logic cf,
                                           input logic te, input logic rdy,
                                           input logic ack, input logic flt);
        return {st, cf, te, rdy, ack, flt};
    endfunction

    // Expected output vector for a steady (non-TEST) phase.
    function automatic logic [7:0] phase_vec(input int st);
        case (st)
            0: return exp_vec(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            1: return exp_vec(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            2: return exp_vec(3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            3: return exp_vec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            5: return exp_vec(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            default: return 8'hxx;
        endcase
    endfunction

    function automatic logic [7:0] model_vec();
        if (m_st == 4) return exp_vec(3'd4, m_tf, 1'b0, 1'b0, 1'b1, 1'b0);
        return phase_vec(m_st);
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic ok;
        ok = vdd_good & vddio_good;
        if (rst) begin
            m_st = 0;
            m_el = 0;
        end else begin
            case (m_st)
                0: if (ok) begin m_st = 1; m_el = 0; end
                1: begin
                    if (!ok) m_st = 0;
                    else begin
                        m_el++;
                        if (m_el == DEB) begin m_st = 2; m_el = 0; end
                    end
                end
                2: begin
                    if (!ok) m_st = 0;
                    else begin
                        m_el++;
                        if (m_el == SET) begin m_st = 3; m_el = 0; end
                    end
                end
                3: if (!ok) m_st = 5; else if (test_req) m_st = 4;
                4: if (!ok) m_st = 5; else if (!test_req) m_st = 3;
                5: if (fault_clr) begin m_st = ok ? 1 : 0; m_el = 0; end
                default: m_st = 0;
            endcase
        end
        m_tf = test_force;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vdd_good = 1'b0; vddio_good = 1'b0;
        test_req = 1'b0; test_force = 1'b0; fault_clr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic go_active();
        do_reset();
        vdd_good = 1'b1; vddio_good = 1'b1;
        repeat (DEB + SET + 1) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs !== phase_vec(0)) $display("FAIL reset_state got=%b exp=%b", obs, phase_vec(0));
        else n_pass++;
        // test_req outside ACTIVE/TEST must be ignored.
        test_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== phase_vec(0)) $display("FAIL req_in_off cyc=%0d got=%b exp=%b", i, obs, phase_vec(0));
            else n_pass++;
        end
        test_req = 1'b0;
    endtask

    task automatic test_powerup();
        logic [7:0] e;
        do_reset();
        vdd_good = 1'b1; vddio_good = 1'b1;
        for (int k = 1; k <= DEB + SET + 1; k++) begin
            tick();
            e = phase_vec((k <= DEB) ? 1 : (k <= DEB + SET) ? 2 : 3);
            n_checks++;
            if (obs !== e) $display("FAIL powerup cyc=%0d got=%b exp=%b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        logic [7:0] e;
        do_reset();
        vdd_good = 1'b1; vddio_good = 1'b1;
        repeat (7) tick();
        vdd_good = 1'b0;
        tick();
        n_checks++;
        if (obs !== phase_vec(0)) $display("FAIL glitch_deb got=%b exp=%b", obs, phase_vec(0));
        else n_pass++;
        vdd_good = 1'b1;
        for (int k = 1; k <= DEB + 1; k++) begin
            tick();
            e = phase_vec((k <= DEB) ? 1 : 2);
            n_checks++;
            if (obs !== e) $display("FAIL glitch_restart cyc=%0d got=%b exp=%b", k, obs, e);
            else n_pass++;
        end
        repeat (20) tick();
        vdd_good = 1'b0;
        tick();
        n_checks++;
        if (obs !== phase_vec(0)) $display("FAIL glitch_settle got=%b exp=%b", obs, phase_vec(0));
        else n_pass++;
        vdd_good = 1'b1;
    endtask

    task automatic test_handshake();
        go_active();
        n_checks++;
        if (obs !== phase_vec(3)) $display("FAIL hs_active got=%b exp=%b", obs, phase_vec(3));
        else n_pass++;
        test_req = 1'b1; test_force = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0))
            $display("FAIL hs_ack got=%b exp=%b", obs, exp_vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        else n_pass++;
        test_force = 1'b1;
        tick();
        n_checks++;
        if (obs !== exp_vec(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0))
            $display("FAIL hs_force1 got=%b exp=%b", obs, exp_vec(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        else n_pass++;
        test_force = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0))
            $display("FAIL hs_force0 got=%b exp=%b", obs, exp_vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        else n_pass++;
        test_req = 1'b0;
        tick();
        n_checks++;
        if (obs !== phase_vec(3)) $display("FAIL hs_release got=%b exp=%b", obs, phase_vec(3));
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        go_active();
        test_req = 1'b1; vdd_good = 1'b0;
        tick();
        n_checks++;
        if (obs !== phase_vec(5)) $display("FAIL simul_fault got=%b exp=%b", obs, phase_vec(5));
        else n_pass++;
        vdd_good = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== phase_vec(5)) $display("FAIL fault_held cyc=%0d got=%b exp=%b", i, obs, phase_vec(5));
            else n_pass++;
        end
        test_req = 1'b0;
    endtask

    task automatic test_fault_recovery();
        logic [7:0] e;
        go_active();
        vdd_good = 1'b0;
        tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++;
        if (obs !== phase_vec(0)) $display("FAIL clr_to_off got=%b exp=%b", obs, phase_vec(0));
        else n_pass++;
        go_active();
        vddio_good = 1'b0;
        tick();
        vddio_good = 1'b1;
        tick();
        n_checks++;
        if (obs !== phase_vec(5)) $display("FAIL fault_sup_back got=%b exp=%b", obs, phase_vec(5));
        else n_pass++;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++;
        if (obs !== phase_vec(1)) $display("FAIL clr_to_deb got=%b exp=%b", obs, phase_vec(1));
        else n_pass++;
        for (int k = 1; k <= DEB; k++) begin
            tick();
            e = phase_vec((k < DEB) ? 1 : 2);
            n_checks++;
            if (obs !== e) $display("FAIL clr_reload cyc=%0d got=%b exp=%b", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        go_active();
        test_req = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd4) $display("FAIL mid_in_test got=%0d exp=4", state);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs !== phase_vec(0)) $display("FAIL mid_reset got=%b exp=%b", obs, phase_vec(0));
        else n_pass++;
        rst = 1'b0; test_req = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] e;
        rst = 1'b1; vdd_good = 1'b0; vddio_good = 1'b0;
        test_req = 1'b0; test_force = 1'b0; fault_clr = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 1499) == 0);
            vdd_good   = ($urandom_range(0, 255) != 0);
            vddio_good = ($urandom_range(0, 255) != 0);
            if ($urandom_range(0, 7) == 0) test_req = ~test_req;
            test_force = 1'($urandom_range(0, 1));
            fault_clr  = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            model_step();
            #1;
            e = model_vec();
            n_checks++;
            if (obs !== e) $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_glitch();
        test_handshake();
        test_simultaneous();
        test_fault_recovery();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
